// File: rtl/clk_pattern_gen_if.sv
// Control and status bundle for the clock pattern generator.
// Handshake: start is a level request accepted only in IDLE with en=1; busy covers HIGH/LOW, done pulses once per finished train.
interface clk_pattern_gen_if #(
    parameter int VOL   = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic             start;
    logic             stop;
    logic [VOL-1:0]   high_len;
    logic [VOL-1:0]   low_len;
    logic [CNT_W-1:0] pulses;
    logic             clk_gen;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output en, start, stop, high_len, low_len, pulses,
        input  clk_gen, busy, done, state_dbg
    );

    modport slave (
        input  en, start, stop, high_len, low_len, pulses,
        output clk_gen, busy, done, state_dbg
    );
endinterface

// File: rtl/clk_pattern_gen.sv
// Programmable pulse-train generator: high/low phase lengths, finite or continuous pulse count, graceful stop.
// All outputs are registered; en=0 freezes everything except reset.
module clk_pattern_gen #(
    parameter int VOL   = 8,
    parameter int CNT_W = 16
) (
    input logic               rdclk,
    input logic               nreset,
    clk_pattern_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    localparam logic [VOL-1:0]   ONE_V = VOL'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           state;
    logic [VOL-1:0]   phase_cnt;
    logic [VOL-1:0]   high_l;
    logic [VOL-1:0]   low_l;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] pulses_l;
    logic             stop_pend;
    logic             clk_gen_r;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] pulse_next;
    logic             last_pulse;

    // Counter wraps naturally in continuous mode since pulses_l==0 never matches.
    assign pulse_next = pulse_cnt + ONE_C;
    assign last_pulse = (pulses_l != '0) && (pulse_next == pulses_l);

    always_ff @(posedge rdclk) begin
        if (!nreset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            high_l    <= ONE_V;
            low_l     <= ONE_V;
            pulse_cnt <= '0;
            pulses_l  <= '0;
            stop_pend <= 1'b0;
            clk_gen_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Zero lengths are stored as 1 so the phase compare never underflows.
                        high_l    <= (bus.high_len == '0) ? ONE_V : bus.high_len;
                        low_l     <= (bus.low_len == '0) ? ONE_V : bus.low_len;
                        pulses_l  <= bus.pulses;
                        phase_cnt <= '0;
                        pulse_cnt <= '0;
                        stop_pend <= 1'b0;
                        state     <= HIGH;
                        clk_gen_r <= 1'b1;
                        busy_r    <= 1'b1;
                    end
                end
                HIGH: begin
                    if (bus.stop) stop_pend <= 1'b1;
                    if (phase_cnt == high_l - ONE_V) begin
                        phase_cnt <= '0;
                        state     <= LOW;
                        clk_gen_r <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + ONE_V;
                    end
                end
                LOW: begin
                    if (bus.stop) stop_pend <= 1'b1;
                    if (phase_cnt == low_l - ONE_V) begin
                        phase_cnt <= '0;
                        pulse_cnt <= pulse_next;
                        // A stop arriving on the final low cycle still ends this train.
                        if (last_pulse || stop_pend || bus.stop) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            state     <= HIGH;
                            clk_gen_r <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + ONE_V;
                    end
                end
                DONE: begin
                    done_r    <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.clk_gen   = clk_gen_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.state_dbg = state;
endmodule

// File: doc/clk_pattern_gen.md
CLK_PATTERN_GEN -- requirements
Module: clk_pattern_gen

Interface
REQ-001 SHALL have parameter VOL, default 8, width of the high/low length fields and the phase counter.
REQ-002 SHALL have parameter CNT_W, default 16, width of the pulse-count field and the pulse counter.
REQ-003 SHALL have port rdclk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  global enable; 0 freezes all state and outputs.
REQ-006 SHALL have port start  input  1  level-sampled request to begin a pulse train.
REQ-007 SHALL have port stop  input  1  request to end the train after the current pulse.
REQ-008 SHALL have port high_len  input  VOL  high-phase length in rdclk cycles.
REQ-009 SHALL have port low_len  input  VOL  low-phase length in rdclk cycles.
REQ-010 SHALL have port pulses  input  CNT_W  number of pulses; 0 = continuous until stop.
REQ-011 SHALL have port clk_gen  output  1  registered generated clock/strobe.
REQ-012 SHALL have port busy  output  1  high in states HIGH and LOW.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking the end of a train.

Function
REQ-014 SHALL implement FSM states IDLE, HIGH, LOW, DONE; all outputs driven from registers.
REQ-015 SHALL, when en=0, hold state, counters, clk_gen, busy and done unchanged; start/stop are ignored that cycle.
REQ-016 SHALL, in IDLE with en=1 and start=1, latch high_len, low_len and pulses, clear counters, and enter HIGH on the next edge.
REQ-017 SHALL treat a latched high_len or low_len of 0 as 1.
REQ-018 SHALL drive clk_gen=1 for exactly max(high_len,1) enabled cycles in HIGH, then enter LOW.
REQ-019 SHALL drive clk_gen=0 for exactly max(low_len,1) enabled cycles in LOW, then increment the pulse counter.
REQ-020 SHALL, at the end of LOW, enter DONE if the counter equals a nonzero latched pulses or a stop is pending; otherwise re-enter HIGH with no gap cycle.
REQ-021 SHALL register a stop seen in HIGH or LOW as pending; the current pulse completes its full high and low phases.
REQ-022 SHALL ignore stop in IDLE and DONE, and ignore start in all states other than IDLE.
REQ-023 SHALL ignore changes to high_len, low_len and pulses while busy=1.
REQ-024 SHALL hold clk_gen=0 and done=1 for exactly one cycle in DONE, then enter IDLE with done=0.
REQ-025 SHALL, in continuous mode (pulses=0), wrap the pulse counter modulo 2^CNT_W without terminating.
REQ-026 SHALL allow start held high to retrigger: when start=1 in IDLE directly after DONE, a new train begins.
REQ-027 SHALL give one cycle of latency from a start sample to the first clk_gen=1.

Reset
REQ-028 SHALL, on the rising rdclk edge with nreset=0, enter IDLE and set clk_gen=0, busy=0, done=0, all counters to 0 and the stop-pending flag to 0, regardless of en.
REQ-029 SHALL, when reset is asserted mid-train, abort with no done pulse; the generator restarts only on a new start after nreset=1.

Verification
REQ-030 SHALL cover: high_len=3, low_len=2, pulses=2, start for 1 cycle -> clk_gen pattern 1,1,1,0,0,1,1,1,0,0; done=1 on the next cycle; busy high for exactly 10 cycles.
REQ-031 SHALL cover: high_len=0, low_len=0, pulses=1 -> one high cycle, one low cycle, then done.
REQ-032 SHALL cover: pulses=0, high_len=2, low_len=2, stop asserted in the 2nd high cycle of pulse 5 -> pulse 5 completes its low phase, then done; no pulse 6.
REQ-033 SHALL cover: en=0 for 4 cycles in the middle of a HIGH phase of length 4 -> clk_gen stays 1 and the total high duration is 8 cycles.
REQ-034 SHALL cover: nreset=0 in LOW of pulse 2 of 3 -> next edge clk_gen=0, busy=0, done=0; new start gives a full 3-pulse train.
REQ-035 SHALL cover: high_len changed from 3 to 7 while busy -> all remaining pulses keep a high length of 3.
